// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter: request record and grant encoding.
package rf_arb_pkg;

    localparam int REG_AW = 5;
    localparam int XLEN   = 32;

    typedef struct packed {
        logic [REG_AW-1:0] waddr;
        logic [XLEN-1:0]   wdata;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_P,
        GNT_M
    } grant_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback-side bus: pipeline write request, multi-cycle result channel and register file write port.
interface rf_wb_arbiter_if;
    import rf_arb_pkg::*;

    logic              p_wr;
    logic [REG_AW-1:0] p_waddr;
    logic [XLEN-1:0]   p_wdata;
    logic              m_valid;
    logic              m_ready;
    logic [REG_AW-1:0] m_waddr;
    logic [XLEN-1:0]   m_wdata;
    logic              rf_wr;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;

    modport master (
        output p_wr, p_waddr, p_wdata, m_valid, m_waddr, m_wdata,
        input  m_ready, rf_wr, rf_waddr, rf_wdata
    );

    modport slave (
        input  p_wr, p_waddr, p_wdata, m_valid, m_waddr, m_wdata,
        output m_ready, rf_wr, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/rf_arb_fifo.sv
// DEPTH-entry synchronous FIFO of writeback requests; occupancy kept in a separate 0..DEPTH count.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  wb_req_t       din,
    output wb_req_t       dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    wb_req_t       mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // NOTE: storage has no reset; stale entries are unreachable because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs buffered multi-cycle results,
// with starvation-forced stall and a busy scoreboard feeding decode hazard detection.
module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREG       = 32,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    rf_wb_arbiter_if.slave    bus,
    input  logic              mc_issue,
    input  logic [REG_AW-1:0] mc_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_wr,
    output logic              hazard_stall,
    output logic              wb_stall,
    output logic              err_drop
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    wb_req_t         fifo_in;
    wb_req_t         fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            fifo_pop;
    logic [CW-1:0]   fifo_count;
    grant_e          grant;
    logic            p_req;
    logic            p_drop;
    logic            stall_d;
    logic [SW-1:0]   starve_q;
    logic [SW-1:0]   starve_d;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Writes to x0 are architecturally void, so they never compete for the port.
    assign p_req       = bus.p_wr && (bus.p_waddr != '0);
    assign bus.m_ready = !fifo_full && !rst;
    assign fifo_push   = bus.m_valid && bus.m_ready;
    assign fifo_in     = '{waddr: bus.m_waddr, wdata: bus.m_wdata};

    rf_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_in),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        grant  = GNT_NONE;
        p_drop = 1'b0;
        if (rst) begin
            grant = GNT_NONE;
        end else if (wb_stall) begin
            p_drop = p_req;
            if (!fifo_empty) grant = GNT_M;
        end else if (p_req) begin
            grant = GNT_P;
        end else if (!fifo_empty) begin
            grant = GNT_M;
        end
    end

    assign fifo_pop = (grant == GNT_M);

    always_comb begin
        bus.rf_wr    = 1'b0;
        bus.rf_waddr = bus.p_waddr;
        bus.rf_wdata = bus.p_wdata;
        case (grant)
            GNT_P: bus.rf_wr = 1'b1;
            GNT_M: begin
                bus.rf_wr    = (fifo_head.waddr != '0);
                bus.rf_waddr = fifo_head.waddr;
                bus.rf_wdata = fifo_head.wdata;
            end
            default: ;
        endcase
    end

    // Reaching the limit forces one stall cycle; pops and an empty FIFO reset the count.
    always_comb begin
        starve_d = starve_q;
        stall_d  = 1'b0;
        if (starve_q == SW'(STARVE_MAX)) begin
            starve_d = '0;
            stall_d  = 1'b1;
        end else if (fifo_pop || fifo_count == '0) begin
            starve_d = '0;
        end else if (grant == GNT_P) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Set is applied after clear so a same-cycle issue to the popped register wins.
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop) busy_d[fifo_head.waddr] = 1'b0;
        if (mc_issue) busy_d[mc_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
            wb_stall <= 1'b0;
            err_drop <= 1'b0;
            busy_q   <= '0;
        end else begin
            starve_q <= starve_d;
            wb_stall <= stall_d;
            err_drop <= err_drop | p_drop;
            busy_q   <= busy_d;
        end
    end

    assign hazard_stall = busy_q[id_rs1] | busy_q[id_rs2] | (id_rd_wr & busy_q[id_rd]);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: expected register file writes queued as stimulus is driven.
module tb_rf_wb_arbiter;
    import rf_arb_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              mc_issue;
    logic [REG_AW-1:0] mc_rd;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic [REG_AW-1:0] id_rd;
    logic              id_rd_wr;
    logic              hazard_stall;
    logic              wb_stall;
    logic              err_drop;

    int      errors = 0;
    int      checks = 0;
    wb_req_t exp_q[$];

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(.NREG(32), .DEPTH(2), .STARVE_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .mc_issue     (mc_issue),
        .mc_rd        (mc_rd),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_rd_wr     (id_rd_wr),
        .hazard_stall (hazard_stall),
        .wb_stall     (wb_stall),
        .err_drop     (err_drop)
    );

    always #5 clk = ~clk;

    // Every register file write must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.rf_wr === 1'b1) begin
            wb_req_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rf_write: unexpected write addr=%0d data=%h, none expected", bus.rf_waddr, bus.rf_wdata);
            end else begin
                e = exp_q.pop_front();
                if (bus.rf_waddr !== e.waddr || bus.rf_wdata !== e.wdata) begin
                    errors++;
                    $display("FAIL rf_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             bus.rf_waddr, bus.rf_wdata, e.waddr, e.wdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [REG_AW-1:0] a, input logic [XLEN-1:0] d);
        exp_q.push_back('{waddr: a, wdata: d});
    endtask

    task automatic idle_inputs();
        bus.p_wr    = 1'b0;
        bus.p_waddr = '0;
        bus.p_wdata = '0;
        bus.m_valid = 1'b0;
        bus.m_waddr = '0;
        bus.m_wdata = '0;
        mc_issue    = 1'b0;
        mc_rd       = '0;
        id_rs1      = '0;
        id_rs2      = '0;
        id_rd       = '0;
        id_rd_wr    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.m_ready !== 1'b0 || bus.rf_wr !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: m_ready=%b rf_wr=%b, expected 0 0", bus.m_ready, bus.rf_wr);
        end
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rf_wr !== 1'b0 || bus.m_ready !== 1'b1 || hazard_stall !== 1'b0 || wb_stall !== 1'b0 || err_drop !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: rf_wr=%b m_ready=%b hazard=%b wb_stall=%b err_drop=%b, expected 0 1 0 0 0",
                     bus.rf_wr, bus.m_ready, hazard_stall, wb_stall, err_drop);
        end
        tick();
    endtask

    task automatic test_p_only();
        bus.p_wr    = 1'b1;
        bus.p_waddr = 5'd5;
        bus.p_wdata = 32'hDEADBEEF;
        expect_write(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if (bus.rf_wr !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL p_write: rf_wr=%b addr=%0d data=%h, expected 1 5 deadbeef", bus.rf_wr, bus.rf_waddr, bus.rf_wdata);
        end
        tick();
        bus.p_waddr = 5'd0;
        @(negedge clk);
        checks++;
        if (bus.rf_wr !== 1'b0) begin
            errors++;
            $display("FAIL p_write_x0: rf_wr=%b, expected 0", bus.rf_wr);
        end
        tick();
        bus.p_wr = 1'b0;
    endtask

    task automatic run_starve(input bit p_in_stall, input logic [XLEN-1:0] mdata);
        bus.m_valid = 1'b1;
        bus.m_waddr = 5'd7;
        bus.m_wdata = mdata;
        bus.p_wr    = 1'b1;
        bus.p_waddr = 5'd3;
        bus.p_wdata = 32'h100;
        expect_write(5'd3, 32'h100);
        @(negedge clk);
        checks++;
        if (bus.m_ready !== 1'b1) begin
            errors++;
            $display("FAIL starve_push: m_ready=%b, expected 1", bus.m_ready);
        end
        tick();
        bus.m_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus.p_wdata = 32'h100 + k;
            expect_write(5'd3, 32'h100 + k);
            @(negedge clk);
            checks++;
            if (wb_stall !== 1'b0) begin
                errors++;
                $display("FAIL starve_wait: cycle %0d wb_stall=%b, expected 0", k, wb_stall);
            end
            tick();
        end
        bus.p_wr    = p_in_stall;
        bus.p_wdata = 32'h0BAD;
        expect_write(5'd7, mdata);
        @(negedge clk);
        checks++;
        if (wb_stall !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== mdata) begin
            errors++;
            $display("FAIL starve_grant: wb_stall=%b addr=%0d data=%h, expected 1 7 %h", wb_stall, bus.rf_waddr, bus.rf_wdata, mdata);
        end
        tick();
        bus.p_wr = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_stall !== 1'b0 || exp_q.size() != 0 || err_drop !== p_in_stall) begin
            errors++;
            $display("FAIL starve_after: wb_stall=%b pending=%0d err_drop=%b, expected 0 0 %b", wb_stall, exp_q.size(), err_drop, p_in_stall);
        end
        tick();
    endtask

    task automatic test_starvation();
        run_starve(1'b0, 32'h11);
        run_starve(1'b1, 32'h11);
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (err_drop !== 1'b1) begin
            errors++;
            $display("FAIL err_drop_sticky: err_drop=%b, expected 1", err_drop);
        end
        tick();
    endtask

    task automatic test_fifo_full();
        bus.p_wr    = 1'b1;
        bus.p_waddr = 5'd3;
        bus.m_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.p_wdata = 32'h200 + k;
            bus.m_waddr = 5'(10 + k);
            bus.m_wdata = 32'hA0 + k;
            expect_write(5'd3, 32'h200 + k);
            @(negedge clk);
            checks++;
            if (bus.m_ready !== (k < 2)) begin
                errors++;
                $display("FAIL fifo_fill: cycle %0d m_ready=%b, expected %b", k, bus.m_ready, (k < 2));
            end
            tick();
        end
        // Entry 12 is still offered: pop-cycle keeps m_ready low, next cycle accepts it.
        bus.p_wr = 1'b0;
        expect_write(5'd10, 32'hA0);
        @(negedge clk);
        checks++;
        if (bus.m_ready !== 1'b0) begin
            errors++;
            $display("FAIL fifo_pop_full: m_ready=%b, expected 0", bus.m_ready);
        end
        tick();
        expect_write(5'd11, 32'hA1);
        @(negedge clk);
        checks++;
        if (bus.m_ready !== 1'b1) begin
            errors++;
            $display("FAIL fifo_reopen: m_ready=%b, expected 1", bus.m_ready);
        end
        tick();
        bus.m_valid = 1'b0;
        expect_write(5'd12, 32'hA2);
        tick();
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL fifo_drain: pending=%0d, expected 0", exp_q.size());
        end
        tick();
    endtask

    task automatic test_scoreboard();
        mc_issue = 1'b1;
        mc_rd    = 5'd9;
        id_rs2   = 5'd9;
        @(negedge clk);
        checks++;
        if (hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL sb_same_cycle: hazard_stall=%b, expected 0", hazard_stall);
        end
        tick();
        mc_issue = 1'b0;
        @(negedge clk);
        checks++;
        if (hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL sb_raw: hazard_stall=%b, expected 1", hazard_stall);
        end
        tick();
        id_rs2   = 5'd0;
        id_rd    = 5'd9;
        id_rd_wr = 1'b1;
        @(negedge clk);
        checks++;
        if (hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL sb_waw: hazard_stall=%b, expected 1", hazard_stall);
        end
        tick();
        id_rd_wr    = 1'b0;
        bus.m_valid = 1'b1;
        bus.m_waddr = 5'd9;
        bus.m_wdata = 32'h99;
        @(negedge clk);
        checks++;
        if (hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL sb_no_write: hazard_stall=%b, expected 0", hazard_stall);
        end
        tick();
        bus.m_valid = 1'b0;
        id_rs2      = 5'd9;
        expect_write(5'd9, 32'h99);
        tick();
        @(negedge clk);
        checks++;
        if (hazard_stall !== 1'b0) begin
            errors++;
            $display("FAIL sb_cleared: hazard_stall=%b, expected 0", hazard_stall);
        end
        mc_issue    = 1'b1;
        bus.m_valid = 1'b1;
        bus.m_wdata = 32'h77;
        tick();
        bus.m_valid = 1'b0;
        expect_write(5'd9, 32'h77);
        tick();
        mc_issue = 1'b0;
        @(negedge clk);
        checks++;
        if (hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL sb_set_wins: hazard_stall=%b, expected 1", hazard_stall);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        mc_issue    = 1'b1;
        mc_rd       = 5'd4;
        bus.p_wr    = 1'b1;
        bus.p_waddr = 5'd3;
        bus.p_wdata = 32'h300;
        bus.m_valid = 1'b1;
        bus.m_waddr = 5'd20;
        bus.m_wdata = 32'h20;
        expect_write(5'd3, 32'h300);
        tick();
        mc_issue    = 1'b0;
        bus.p_wdata = 32'h301;
        bus.m_waddr = 5'd21;
        bus.m_wdata = 32'h21;
        expect_write(5'd3, 32'h301);
        tick();
        bus.p_wr    = 1'b0;
        bus.m_valid = 1'b0;
        id_rs1      = 5'd4;
        rst         = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rf_wr !== 1'b0 || bus.m_ready !== 1'b0 || hazard_stall !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_hold: rf_wr=%b m_ready=%b hazard=%b, expected 0 0 1", bus.rf_wr, bus.m_ready, hazard_stall);
        end
        tick();
        rst    = 1'b0;
        id_rs2 = 5'd9;
        @(negedge clk);
        checks++;
        if (bus.rf_wr !== 1'b0 || bus.m_ready !== 1'b1 || hazard_stall !== 1'b0 || wb_stall !== 1'b0 || err_drop !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_after: rf_wr=%b m_ready=%b hazard=%b wb_stall=%b err_drop=%b, expected 0 1 0 0 0",
                     bus.rf_wr, bus.m_ready, hazard_stall, wb_stall, err_drop);
        end
        tick();
        tick();
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_p_only();
        test_starvation();
        test_fifo_full();
        test_scoreboard();
        test_mid_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected writes never seen, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Shares the register file's single write port between two requesters: the pipeline writeback stage (P) and a multi-cycle execution unit (M, e.g. a divider). It buffers M results in a small FIFO and forces a one-cycle pipeline stall when M has been starved. It also keeps a busy scoreboard of registers awaiting an M result and flags RAW/WAW hazards to the decode stage. It sits between the writeback stage, the multi-cycle unit, and the register file write port.

Parameters:
XLEN, 32, data width
NREG, 32, number of architectural registers (address width = log2(NREG) = 5)
DEPTH, 2, M result FIFO entries (power of 2, at least 1)
STARVE_MAX, 4, consecutive cycles M may lose arbitration before a forced grant

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
p_wr  in  1  pipeline writeback request; cannot be back-pressured
p_waddr  in  5  pipeline destination register
p_wdata  in  XLEN  pipeline write data
m_valid  in  1  M result valid
m_ready  out  1  FIFO can accept an M result
m_waddr  in  5  M destination register
m_wdata  in  XLEN  M result data
mc_issue  in  1  decode issues an op to M this cycle
mc_rd  in  5  destination register of the issued M op
id_rs1  in  5  decode source register 1
id_rs2  in  5  decode source register 2
id_rd  in  5  decode destination register
id_rd_wr  in  1  decode instruction writes id_rd
hazard_stall  out  1  decode must hold (scoreboard hit)
wb_stall  out  1  pipeline must freeze for one cycle; P must drive p_wr=0 in that cycle
rf_wr  out  1  register file write enable
rf_waddr  out  5  register file write address
rf_wdata  out  XLEN  register file write data
err_drop  out  1  sticky flag: a P write was dropped

Behaviour:
Reset (rst=1 at posedge):
- FIFO emptied; busy[] cleared; starvation counter cleared.
- wb_stall=0 and err_drop=0.
- While rst is high: m_ready=0 and rf_wr=0.

Arbitration (combinational within the cycle; the register file samples the write on negedge):
- A P write to x0 is treated as no request.
- If wb_stall=1: grant goes to the FIFO head if the FIFO is non-empty.
  - If p_wr=1 with a nonzero p_waddr in that cycle, the P write is dropped and err_drop is set.
- Otherwise P wins whenever it requests. If P does not request and the FIFO is non-empty, the FIFO head is granted and popped at posedge.
- rf_wr=0 when nothing is granted.
- An M result with m_waddr=0 is enqueued. It pops normally but drives rf_wr=0.

FIFO:
- Push when m_valid and m_ready. m_ready = !full && !rst.
- Push and pop in the same cycle are both allowed, including when full: m_ready stays low when full, with no lookahead.
- Minimum M latency is one cycle: push at posedge N, earliest write in cycle N+1. There is no bypass.
- Read and write pointers wrap modulo DEPTH. Occupancy is tracked with a separate count register sized 0..DEPTH.

Starvation:
- The counter increments on every cycle in which the FIFO is non-empty and P wins.
- The counter clears on any FIFO pop or when the FIFO is empty.
- When the counter equals STARVE_MAX at posedge, wb_stall goes to 1 for exactly the next cycle and the counter clears.
- wb_stall is registered, so its assertion has a one-cycle latency.

Scoreboard busy[NREG]:
- mc_issue with nonzero mc_rd sets busy[mc_rd].
- A granted FIFO pop clears busy[head.waddr].
- If a set and a clear hit the same register in the same cycle, the set wins.
- busy[0] is hardwired to 0.

Hazard detection:
- hazard_stall = busy[id_rs1] | busy[id_rs2] | (id_rd_wr & busy[id_rd]).
- hazard_stall is combinational from current state and does not see same-cycle updates.

Reset mid-operation:
- Any FIFO contents are discarded with no write.
- wb_stall drops on the next cycle.

Decomposition:
- Package rf_arb_pkg holds:
  - constants REG_AW=5 and XLEN
  - typedef wb_req_t with fields waddr [4:0] and wdata [XLEN-1:0]
  - enum grant_e with values GNT_NONE, GNT_P, GNT_M
- One sub-module: rf_arb_fifo, a parameterised DEPTH-entry synchronous FIFO of wb_req_t with full/empty/count outputs.
- The scoreboard, arbiter and starvation counter stay in the top module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> rf_wr=0, m_ready=1, hazard_stall=0, wb_stall=0.
- P only: p_wr=1, p_waddr=5, p_wdata=0xDEADBEEF -> same cycle rf_wr=1, rf_waddr=5, rf_wdata=0xDEADBEEF. With p_waddr=0 -> rf_wr=0.
- Contention and starvation: push M (waddr=7, wdata=0x11) while p_wr=1 (to x3) every cycle -> counter reaches 4 and wb_stall=1 in the next cycle. In that cycle with p_wr=0: rf_waddr=7, rf_wdata=0x11, FIFO empties. Repeat with p_wr=1 during wb_stall -> err_drop=1, and it stays set.
- FIFO full: no P traffic blocked, two M pushes while rf writes are suppressed by a P stream -> m_ready=0 after 2 pushes. One pop in a cycle with m_valid=1 -> m_ready returns to 1 the following cycle.
- Scoreboard RAW/WAW: mc_issue, mc_rd=9; next cycle id_rs2=9 -> hazard_stall=1. With id_rd=9, id_rd_wr=1 -> hazard_stall=1. After M writes x9 via the FIFO -> hazard_stall=0. Same-cycle pop of x9 and mc_issue x9 -> busy[9] remains 1.
- Mid-operation reset: FIFO holding 2 entries, busy[4]=1, rst=1 for 1 cycle -> no rf_wr, busy cleared, FIFO empty, m_ready=1 after rst deasserts.
